inst_fetch_buf: RTL

Instruction fetch buffer between the PC unit and the decode stage of the hxd32 core. It:
- takes the current fetch address from the PC unit and issues requests to instruction memory over a request/grant port;
- pulses an acknowledge so control can advance the PC;
- queues returned instruction words with their PC in an in-order FIFO for decode;
- discards in-flight and queued words on a redirect flush.

---
 rtl/inst_fetch_buf_pkg.sv | 16 +
 rtl/inst_fetch_buf_sync_fifo.sv | 59 +++++
 rtl/inst_fetch_buf.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_buf_pkg.sv
// Shared types for the hxd32 instruction fetch buffer: FSM state and queued entry layout.
package inst_fetch_buf_pkg;

    localparam int unsigned IFB_XLEN = 32;

    typedef enum logic [0:0] {
        IFB_IDLE = 1'b0,
        IFB_REQ  = 1'b1
    } ifb_state_e;

    typedef struct packed {
        logic [IFB_XLEN-1:0] pc;
        logic [IFB_XLEN-1:0] inst;
    } ifb_entry_t;

endpackage

// File: rtl/inst_fetch_buf_sync_fifo.sv
// Synchronous FIFO with registered storage, clear, and full/empty/count status.
// DEPTH must be a power of two so the pointers wrap naturally.
module inst_fetch_buf_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only accepted when a pop frees a slot the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: issues imem requests, tracks in-flight PCs, queues words for decode.
// Optional IFB_BYPASS_EN: forward a response straight to decode when the queue is empty.
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_data_i,
    output logic            fetch_ack_o,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_data_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    ifb_state_e      state_q;
    logic [XLEN-1:0] addr_q;
    logic            stale_q;
    logic [CW-1:0]   discard_q;

    logic [CW-1:0]   infl_cnt;
    logic [CW-1:0]   inst_cnt;
    logic [XLEN-1:0] infl_pc;
    logic            infl_empty;
    logic            infl_full;
    logic            inst_empty;
    logic            inst_full;
    ifb_entry_t      inst_head;
    ifb_entry_t      inst_new;

    logic            grant;
    logic            rsp;
    logic            rsp_live;
    logic            inst_push;
    logic            inst_pop;
    logic [SW-1:0]   used;
    logic            has_credit;
    logic            credit_after;
    logic [XLEN-1:0] next_pc;

    assign grant        = (state_q == IFB_REQ) && imem_gnt_i;
    assign rsp          = imem_rvalid_i && !infl_empty;
    assign rsp_live     = rsp && (discard_q == '0) && !flush_i;
    assign used         = SW'(infl_cnt) + SW'(inst_cnt);
    assign has_credit   = used < SW'(DEPTH);
    assign credit_after = (used + SW'(1)) < SW'(DEPTH);

    assign fetch_ack_o  = grant && !stale_q && !flush_i;
    assign imem_req_o   = (state_q == IFB_REQ);
    assign imem_addr_o  = addr_q;

    // Control writes PC+4 on ack, so the address for a back-to-back request is known now.
    assign next_pc = fetch_ack_o ? pc_data_i + XLEN'(4) : pc_data_i;

    assign inst_new = '{pc: infl_pc, inst: imem_rdata_i};

    always_comb begin
        inst_push    = rsp_live;
        inst_pop     = !inst_empty && inst_ready_i;
        inst_valid_o = !inst_empty;
        inst_data_o  = inst_head.inst;
        inst_pc_o    = inst_head.pc;
`ifdef IFB_BYPASS_EN
        if (inst_empty && rsp_live) begin
            inst_valid_o = 1'b1;
            inst_data_o  = imem_rdata_i;
            inst_pc_o    = infl_pc;
            inst_push    = !inst_ready_i;
        end
`endif
    end

    // Request FSM plus discard bookkeeping for words made stale by a redirect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IFB_IDLE;
            addr_q    <= '0;
            stale_q   <= 1'b0;
            discard_q <= '0;
        end else begin
            unique case (state_q)
                IFB_IDLE: begin
                    if (has_credit && !flush_i) begin
                        state_q <= IFB_REQ;
                        addr_q  <= {pc_data_i[XLEN-1:2], 2'b00};
                        stale_q <= 1'b0;
                    end
                end
                IFB_REQ: begin
                    if (imem_gnt_i) begin
                        stale_q <= 1'b0;
                        if (credit_after && !flush_i) begin
                            addr_q <= {next_pc[XLEN-1:2], 2'b00};
                        end else begin
                            state_q <= IFB_IDLE;
                        end
                    end else if (flush_i) begin
                        stale_q <= 1'b1;
                    end
                end
                default: state_q <= IFB_IDLE;
            endcase

            if (flush_i) begin
                discard_q <= infl_cnt - CW'(rsp) + CW'(state_q == IFB_REQ);
            end else if (rsp && (discard_q != '0)) begin
                discard_q <= discard_q - CW'(1);
            end
        end
    end

    inst_fetch_buf_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_infl_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (1'b0),
        .push_i      (grant),
        .push_data_i (addr_q),
        .pop_i       (rsp),
        .pop_data_o  (infl_pc),
        .full_o      (infl_full),
        .empty_o     (infl_empty),
        .count_o     (infl_cnt)
    );

    inst_fetch_buf_sync_fifo #(
        .WIDTH ($bits(ifb_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (flush_i),
        .push_i      (inst_push),
        .push_data_i (inst_new),
        .pop_i       (inst_pop),
        .pop_data_o  (inst_head),
        .full_o      (inst_full),
        .empty_o     (inst_empty),
        .count_o     (inst_cnt)
    );

    a_rvalid_needs_inflight: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_rvalid_i |-> !infl_empty);
    a_infl_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        grant |-> (!infl_full || rsp));
    a_inst_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        inst_push |-> (!inst_full || inst_pop));

endmodule
